// File: rtl/fdiv_share_ctrl.sv
// ---------------------------------------------------------------------------
// fdiv_share_ctrl
// Shares one iterative Newton-Raphson mantissa divider between N_REQ
// requesters. Operand pairs are accepted one at a time through a round-robin
// valid/ready port. The operands are presented to the divider with a
// single-cycle start strobe, and the fixed divider latency is counted. The
// 32-bit quotient is then returned together with the requester id and tag
// on a buffered valid/ready response port.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset (abandons any operation)
//   req_valid  : per-requester request present
//   req_ready  : one-hot grant, only in IDLE (combinational)
//   req_a/b    : packed 24-bit mantissas, requester i at [24i+23:24i]
//   req_tag    : packed TAG_W-bit tags, same packing
//   div_start  : one-cycle start strobe to the divider
//   div_a/b    : operands held stable from ISSUE through WAIT
//   div_busy   : divider stall; delays the start strobe
//   div_q      : divider quotient, valid DIV_LAT cycles after the strobe
//   rsp_valid  : response held until rsp_ready
//   rsp_ready  : consumer accepts the response
//   rsp_q      : captured quotient
//   rsp_id     : index of the issuing requester
//   rsp_tag    : tag of the issuing request
// ---------------------------------------------------------------------------
module fdiv_share_ctrl #(
    parameter int N_REQ   = 2,
    parameter int DIV_LAT = 16,
    parameter int TAG_W   = 4,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int CNT_W  = $clog2(DIV_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [24*N_REQ-1:0]      req_a,
    input  logic [24*N_REQ-1:0]      req_b,
    input  logic [TAG_W*N_REQ-1:0]   req_tag,
    output logic                     div_start,
    output logic [23:0]              div_a,
    output logic [23:0]              div_b,
    input  logic                     div_busy,
    input  logic [31:0]              div_q,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_q,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ID_W:0]    N_WRAP    = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]  ID_ONE    = ID_W'(1);
    localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

    state_t             state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [TAG_W-1:0]   op_tag_r;
    logic [ID_W-1:0]    op_id_r;

    logic [ID_W:0]      cand_s;
    logic [ID_W-1:0]    idx_s;
    logic               grant_hit_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [N_REQ-1:0]   grant_s;
    logic [ID_W-1:0]    next_ptr_s;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_id_s  = '0;
        cand_s      = '0;
        idx_s       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
            // cand_s never reaches 2*N_REQ, so one subtraction is a full modulo
            if (cand_s >= N_WRAP) begin
                idx_s = ID_W'(cand_s - N_WRAP);
            end else begin
                idx_s = ID_W'(cand_s);
            end
            if (!grant_hit_s && req_valid[idx_s]) begin
                grant_hit_s = 1'b1;
                grant_id_s  = idx_s;
            end else begin
                grant_id_s  = grant_id_s;
            end
        end
    end

    // Grant decode, next pointer and the two combinational handshake outputs.
    always_comb begin
        grant_s    = '0;
        next_ptr_s = '0;
        req_ready  = '0;
        div_start  = 1'b0;
        if (grant_hit_s) begin
            grant_s = GRANT_LSB << grant_id_s;
        end else begin
            grant_s = '0;
        end
        if (grant_id_s == ID_LAST) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_id_s + ID_ONE;
        end
        if ((state_r == ST_IDLE) && !rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        // Strobe only in ISSUE with the divider free; leaving ISSUE on the same
        // edge guarantees it never lasts two cycles.
        if ((state_r == ST_ISSUE) && !div_busy && !rst) begin
            div_start = 1'b1;
        end else begin
            div_start = 1'b0;
        end
    end

    // Operation sequencer: accept, issue, count latency, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            cnt_r     <= '0;
            op_tag_r  <= '0;
            op_id_r   <= '0;
            div_a     <= 24'h000000;
            div_b     <= 24'h000000;
            rsp_valid <= 1'b0;
            rsp_q     <= 32'h0000_0000;
            rsp_id    <= '0;
            rsp_tag   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_hit_s) begin
                        div_a    <= req_a[24*grant_id_s +: 24];
                        div_b    <= req_b[24*grant_id_s +: 24];
                        op_tag_r <= req_tag[TAG_W*grant_id_s +: TAG_W];
                        op_id_r  <= grant_id_s;
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!div_busy) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // div_a/div_b are deliberately untouched: the divider
                    // samples them one cycle after the strobe.
                    if (cnt_r == CNT_LAST) begin
                        rsp_q     <= div_q;
                        rsp_id    <= op_id_r;
                        rsp_tag   <= op_tag_r;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fdiv_share_ctrl
// Bench for fdiv_share_ctrl with N_REQ=2, DIV_LAT=16, TAG_W=4. The reference
// model tracks the operation in flight as timestamps: the acceptance, the
// cycle the strobe fired, and the response window. A toy divider returns a
// quotient only in the exact cycle it is due, so latency errors corrupt
// rsp_q. Inputs change 1 time unit after the rising edge. Outputs are
// sampled there as well.
// ---------------------------------------------------------------------------
module tb_fdiv_share_ctrl;

    localparam int N   = 2;
    localparam int LAT = 16;
    localparam int TW  = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [24*N-1:0]    req_a;
    logic [24*N-1:0]    req_b;
    logic [TW*N-1:0]    req_tag;
    logic               div_start;
    logic [23:0]        div_a;
    logic [23:0]        div_b;
    logic               div_busy;
    logic [31:0]        div_q;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_q;
    logic [0:0]         rsp_id;
    logic [TW-1:0]      rsp_tag;

    fdiv_share_ctrl #(.N_REQ(N), .DIV_LAT(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_q(div_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus knobs
    bit rst_k;
    int busy_mode;    // 0 low, 1 random
    int busy_hold;    // forced busy cycles while an op waits to start
    int rdy_mode;     // 0 low, 1 high, 2 random
    int refill_mode;  // 0 none, 1 always, 2 random

    // requester side
    bit             pend [N];
    logic [23:0]    pa [N];
    logic [23:0]    pb [N];
    logic [TW-1:0]  pt [N];

    // reference model
    bit             m_live;
    int             m_start;
    int             m_id;
    logic [23:0]    m_a, m_b;
    logic [TW-1:0]  m_tag;
    int             m_ptr;
    int             m_done;
    logic [23:0]    dv_a, dv_b;

    // observations of the DUT
    int             dut_grants [$];
    int             dut_rsp_cnt;
    int             last_acc, last_start, last_rv;
    logic [31:0]    last_q;
    bit             prev_rv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout, got no completion expected completion (cycle %0d)", tag, cyc);
    endtask

    // Toy divider: an arbitrary but operand-dependent quotient; 2/3 is exact.
    function automatic logic [31:0] div_fn(input logic [23:0] a, input logic [23:0] b);
        logic [7:0] lo;
        if ((a == 24'h800000) && (b == 24'hC00000)) return 32'h5555_5555;
        lo = a[7:0] ^ 8'h3C;
        return {a ^ b, lo};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_op(input int i);
        pa[i] = {1'b1, 23'($urandom)};
        pb[i] = {1'b1, 23'($urandom)};
        pt[i] = TW'($urandom);
    endtask

    // One clock cycle: check, drive, check combinational outputs, advance.
    task automatic run_cycle();
        int g;
        bit exp_rv;
        bit exp_ds;
        logic [N-1:0] hs;
        logic [31:0] obs_q;
        logic [31:0] exp_rdy;

        exp_rv = m_live && (m_start >= 0) && (cyc >= m_start + LAT + 1);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check_eq("rsp_q", rsp_q, div_fn(m_a, m_b));
            check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
            check_eq("rsp_tag", 32'(rsp_tag), 32'(m_tag));
        end
        if (m_live) begin
            check_eq("div_a", 32'(div_a), 32'(m_a));
            check_eq("div_b", 32'(div_b), 32'(m_b));
        end
        if (m_live && (m_start >= 0) && (cyc == m_start + 1)) begin
            dv_a = div_a;
            dv_b = div_b;
        end
        if (rsp_valid && !prev_rv) last_rv = cyc;
        prev_rv = rsp_valid;

        // drive inputs
        if (refill_mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
                    pend[i] = 1'b1;
                    new_op(i);
                end
            end
        end
        rst = rst_k;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_a[24*i +: 24]     = pa[i];
            req_b[24*i +: 24]     = pb[i];
            req_tag[TW*i +: TW]   = pt[i];
        end
        if ((busy_hold > 0) && m_live && (m_start < 0)) begin
            div_busy = 1'b1;
            busy_hold--;
        end else if (busy_mode == 1) begin
            div_busy = ($urandom_range(0, 2) == 0);
        end else begin
            div_busy = 1'b0;
        end
        if (rdy_mode == 0)      rsp_ready = 1'b0;
        else if (rdy_mode == 1) rsp_ready = 1'b1;
        else                    rsp_ready = ($urandom_range(0, 1) == 1);
        if (m_live && (m_start >= 0) && (cyc == m_start + LAT)) div_q = div_fn(dv_a, dv_b);
        else                                                    div_q = $urandom;

        #1;
        g = (!m_live && !rst_k) ? rr_pick(req_valid, m_ptr) : -1;
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        exp_ds  = m_live && (m_start < 0) && !div_busy && !rst_k;
        check_eq("req_ready", 32'(req_ready), exp_rdy);
        check_eq("div_start", 32'(div_start), 32'(exp_ds));
        hs    = req_valid & req_ready;
        obs_q = rsp_q;
        if (div_start) last_start = cyc;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                dut_grants.push_back(i);
                last_acc = cyc;
            end
        end
        if (rsp_valid && rsp_ready) dut_rsp_cnt++;

        @(posedge clk);
        // model consequences of this cycle's edge
        if (rst_k) begin
            m_live = 1'b0;
            m_ptr  = 0;
        end else if (!m_live) begin
            if (g >= 0) begin
                m_live  = 1'b1;
                m_start = -1;
                m_id    = g;
                m_a     = pa[g];
                m_b     = pb[g];
                m_tag   = pt[g];
                m_ptr   = (g + 1) % N;
            end
        end else if (m_start < 0) begin
            if (!div_busy) m_start = cyc;
        end else if (exp_rv && rsp_ready) begin
            last_q = obs_q;
            m_live = 1'b0;
            m_done++;
        end
        // requesters drop or renew after a real transfer
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if ((refill_mode == 1) || ((refill_mode == 2) && ($urandom_range(0, 1) == 1))) begin
                    pend[i] = 1'b1;
                    new_op(i);
                end else begin
                    pend[i] = 1'b0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int b;
        b = budget;
        while ((m_done < target) && (b > 0)) begin
            run_cycle();
            b--;
        end
        if (m_done < target) fail_timeout(tag);
    endtask

    initial begin
        int n0;
        int b;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
        div_busy = 1'b0; div_q = 32'h0; rsp_ready = 1'b0;
        rst_k = 1'b1; busy_mode = 0; busy_hold = 0; rdy_mode = 1; refill_mode = 1;
        m_live = 1'b0; m_start = -1; m_id = 0; m_ptr = 0; m_done = 0;
        m_a = '0; m_b = '0; m_tag = '0; dv_a = '0; dv_b = '0;
        dut_rsp_cnt = 0; last_acc = 0; last_start = 0; last_rv = 0; last_q = '0; prev_rv = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            new_op(i);
        end
        repeat (2) @(posedge clk);
        #1;

        // reset held with both requests valid
        repeat (2) run_cycle();
        check_eq("rst_div_a", 32'(div_a), 32'h0);
        check_eq("rst_div_b", 32'(div_b), 32'h0);
        check_eq("rst_rsp_q", rsp_q, 32'h0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'h0);
        rst_k = 1'b0;

        // round-robin with both requesters always valid
        wait_done(4, 200, "rr_ops");
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        refill_mode = 0;
        check_eq("rr_count", 32'(dut_grants.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < dut_grants.size()) check_eq("rr_order", 32'(dut_grants[k]), 32'(k % 2));
        end
        run_cycle();

        // single directed op: 2/3
        pend[0] = 1'b1; pa[0] = 24'h800000; pb[0] = 24'hC00000; pt[0] = 4'd5;
        wait_done(5, 60, "single_op");
        check_eq("single_q", last_q, 32'h5555_5555);
        check_eq("single_start_lat", 32'(last_start - last_acc), 32'd1);
        check_eq("single_rsp_lat", 32'(last_rv - last_acc), 32'(LAT + 2));

        // backpressure: hold rsp_ready low 10 cycles after rsp_valid
        rdy_mode = 0;
        pend[0] = 1'b1; new_op(0);
        pend[1] = 1'b1; new_op(1);
        b = 60;
        while (!(m_live && (m_start >= 0) && (cyc >= m_start + LAT + 1)) && (b > 0)) begin
            run_cycle();
            b--;
        end
        if (b == 0) fail_timeout("bp_rsp");
        repeat (10) run_cycle();
        rdy_mode = 1;
        n0 = dut_grants.size();
        repeat (2) run_cycle();
        check_eq("bp_regrant", 32'(dut_grants.size() - n0), 32'd1);
        wait_done(7, 60, "bp_second");

        // divider busy for 3 cycles in ISSUE
        pend[0] = 1'b1; new_op(0);
        busy_hold = 3;
        wait_done(8, 60, "busy_op");
        check_eq("busy_start_lat", 32'(last_start - last_acc), 32'd4);
        check_eq("busy_rsp_lat", 32'(last_rv - last_start), 32'(LAT + 1));

        // reset in WAIT at cnt=8, then a normal op
        pend[0] = 1'b1; new_op(0);
        b = 60;
        while (!(m_live && (m_start >= 0) && (cyc == m_start + 8)) && (b > 0)) begin
            run_cycle();
            b--;
        end
        if (b == 0) fail_timeout("mid_wait");
        rst_k = 1'b1;
        run_cycle();
        rst_k = 1'b0;
        pend[1] = 1'b1; new_op(1);
        wait_done(9, 60, "after_rst");

        // randomized traffic
        busy_mode = 1; rdy_mode = 2; refill_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            rst_k = ($urandom_range(0, 299) == 0);
            run_cycle();
        end
        rst_k = 1'b0;
        check_eq("rsp_count", 32'(dut_rsp_cnt), 32'(m_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fdiv_share_ctrl.md
Name: fdiv_share_ctrl

Overview:
- Controller/arbiter that shares one iterative Newton-Raphson mantissa divider between N_REQ requesters, e.g. two issue ports or an FP divide and a reciprocal-estimate path.
- Accepts operand pairs with a valid/ready handshake and grants round-robin.
- Drives the divider start strobe, holds operands stable for the whole iteration, and times the fixed divider latency.
- Returns the 32-bit quotient with requester id and tag through a buffered valid/ready response port.

Parameters:
N_REQ, 2, number of requesters (2..4)
DIV_LAT, 16, cycles from the start-strobe cycle to a valid quotient on div_q
TAG_W, 4, width of the opaque per-request tag

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  request present, one bit per requester
req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
req_a  in  24*N_REQ  dividend mantissas .1xxx..x, requester i at [24i+23:24i]
req_b  in  24*N_REQ  divisor mantissas .1xxx..x, same packing
req_tag  in  TAG_W*N_REQ  tags, same packing
div_start  out  1  one-cycle start strobe to the divider (its fdiv input)
div_a  out  24  dividend to the divider
div_b  out  24  divisor to the divider
div_busy  in  1  divider busy/stall indication
div_q  in  32  divider quotient x.xxx..x, sticky in bit 0
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_q  out  32  quotient
rsp_id  out  clog2(N_REQ)  index of the requester that issued the operation
rsp_tag  out  TAG_W  tag of the issuing request

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Only one operation is in flight at a time.
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, cnt=0.
  - Outputs after reset: req_ready=0, div_start=0, div_a=0, div_b=0, rsp_valid=0, rsp_q=0, rsp_id=0, rsp_tag=0.
  - Reset mid-operation abandons the operation; no response is produced. The divider's own reset is separate.
- IDLE:
  - req_ready is combinational and one-hot. It selects the first valid requester searching from rr_ptr upward, wrapping modulo N_REQ. It is 0 when no request is valid.
  - On a transfer: latch a/b/tag/id into div_a/div_b/op_tag/op_id, set rr_ptr = granted+1 (mod N_REQ), go to ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE:
  - If div_busy=1: wait in ISSUE with div_start=0.
  - Otherwise: assert div_start=1 for exactly this cycle, set cnt=1, go to WAIT.
  - div_start is never high for two consecutive cycles.
- WAIT:
  - cnt increments each cycle.
  - When cnt==DIV_LAT, on that edge: capture rsp_q<=div_q, rsp_id<=op_id, rsp_tag<=op_tag, set rsp_valid<=1, go to DONE.
  - div_a/div_b stay constant from ISSUE through WAIT, because the divider samples operands one cycle after start.
- DONE:
  - Hold rsp_valid=1 and stable rsp_* until rsp_ready=1.
  - On that edge: rsp_valid<=0, go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Latency:
  - Request accepted at edge T; div_start high in cycle T+1; rsp_valid rises at edge T+1+DIV_LAT.
  - With rsp_ready held high and div_busy low, back-to-back accepts are spaced DIV_LAT+3 cycles.
- Fairness: a continuously valid requester waits at most N_REQ-1 operations.
- Requests arriving in non-IDLE states are held by the requester; the block neither drops nor queues them.
- Simultaneous valid on all inputs in IDLE: exactly one grant, by rr_ptr.
- cnt width: clog2(DIV_LAT+1); no wrap occurs within WAIT.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=2'b11 -> req_ready=0, div_start=0, rsp_valid=0. First IDLE cycle after release grants requester 0.
- Single op: req0 a=24'h800000, b=24'hC00000, tag=5 accepted at T -> div_start only at T+1, div_a/div_b stable through WAIT. Divider model returns 32'h5555_5555 at cnt=16 -> rsp_valid at T+17 with rsp_q=32'h55555555, rsp_id=0, rsp_tag=5.
- Round-robin: req_valid=2'b11 held for 4 operations -> grant order 0,1,0,1; each response carries the matching id and tag.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, no div_start. First cycle after rsp_ready=1 returns to IDLE and grants the next request.
- Divider busy: div_busy=1 for 3 cycles while in ISSUE -> div_start delayed 3 cycles, then a single-cycle pulse; latency measured from the pulse.
- Reset mid-WAIT: rst=1 at cnt=8 -> IDLE next cycle, no rsp_valid pulse, next operation completes normally.
